// File: rtl/fifo_reader_pkg.sv
// fifo_reader_pkg: shared FSM encoding and FIFO read timing for the FIFO read-side controller.
package fifo_reader_pkg;
    typedef enum logic [1:0] {RD_IDLE, RD_STREAM, RD_BURST} rd_state_t;
    localparam int FIFO_RD_LATENCY = 1;
endpackage

// File: rtl/fifo_rd_buf.sv
// fifo_rd_buf: 2-entry in-order valid/ready output buffer; head entry always sits in slot 0.
module fifo_rd_buf #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_push,
    input  logic [DATA_WIDTH-1:0] i_push_data,
    input  logic                  i_flush,
    input  logic                  i_pop,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_valid,
    output logic [1:0]            o_occ
);
    logic [DATA_WIDTH-1:0] r_mem [2];
    logic [1:0]            r_occ;
    logic [1:0]            w_slot;
    // a push lands behind whatever survives this cycle's pop
    assign w_slot  = r_occ - {1'b0, i_pop};
    assign o_data  = r_mem[0];
    assign o_valid = r_occ != 2'd0;
    assign o_occ   = r_occ;
    always_ff @(posedge clk) begin
        if (reset) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_occ    <= '0;
        end else if (i_flush) begin
            r_occ <= '0;
        end else begin
            if (i_pop) r_mem[0] <= r_mem[1];
            if (i_push) r_mem[w_slot[0]] <= i_push_data;
            r_occ <= r_occ + {1'b0, i_push} - {1'b0, i_pop};
        end
    end
endmodule

// File: rtl/fifo_reader.sv
// fifo_reader: drains a synchronous FIFO in stream or burst mode onto a valid/ready stream.
module fifo_reader
    import fifo_reader_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int BURST_LEN  = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  fifo_empty,
    input  logic                  fifo_thresh,
    input  logic                  fifo_underflow,
    input  logic [DATA_WIDTH-1:0] fifo_data,
    output logic                  fifo_rd,
    input  logic                  burst_en,
    input  logic                  flush,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic                  burst_done,
    output logic                  err,
    output logic [15:0]           words_read
);
    rd_state_t                  r_state;
    logic [7:0]                 r_burst_cnt;
    logic [FIFO_RD_LATENCY-1:0] r_rd_pipe;
    logic                       r_burst_done;
    logic                       r_err;
    logic [15:0]                r_words;
    logic [1:0]                 w_occ;
    logic                       w_inflight;
    logic                       w_pop;
    logic                       w_push;
    logic [2:0]                 w_need;
    assign w_inflight = r_rd_pipe[FIFO_RD_LATENCY-1];
    assign w_pop      = m_valid && m_ready && !flush;
    assign w_push     = w_inflight && !flush;
    // buffer slots already claimed once this cycle's pop is accounted for
    assign w_need     = {1'b0, w_occ} + {2'b0, w_inflight} - {2'b0, w_pop};
    assign fifo_rd    = !fifo_empty && !flush && r_state != RD_IDLE && w_need < 3'd2;
    assign burst_done = r_burst_done;
    assign err        = r_err;
    assign words_read = r_words;
    fifo_rd_buf #(.DATA_WIDTH(DATA_WIDTH)) u_buf (
        .clk         (clk),
        .reset       (reset),
        .i_push      (w_push),
        .i_push_data (fifo_data),
        .i_flush     (flush),
        .i_pop       (w_pop),
        .o_data      (m_data),
        .o_valid     (m_valid),
        .o_occ       (w_occ)
    );
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= RD_IDLE;
            r_burst_cnt  <= '0;
            r_rd_pipe    <= '0;
            r_burst_done <= 1'b0;
            r_err        <= 1'b0;
            r_words      <= '0;
        end else begin
            r_rd_pipe    <= FIFO_RD_LATENCY'({r_rd_pipe, fifo_rd});
            r_err        <= r_err || fifo_underflow || (fifo_rd && fifo_empty);
            r_words      <= r_words + {15'd0, w_pop};
            r_burst_done <= 1'b0;
            if (flush) begin
                r_state <= RD_IDLE;
            end else begin
                unique case (r_state)
                    RD_IDLE: begin
                        if (!burst_en) begin
                            r_state <= RD_STREAM;
                        end else if (fifo_thresh) begin
                            r_state     <= RD_BURST;
                            r_burst_cnt <= 8'(BURST_LEN);
                        end
                    end
                    RD_STREAM: if (burst_en) r_state <= RD_IDLE;
                    RD_BURST: begin
                        if (fifo_rd) begin
                            r_burst_cnt <= r_burst_cnt - 8'd1;
                            if (r_burst_cnt == 8'd1) begin
                                r_state      <= RD_IDLE;
                                r_burst_done <= 1'b1;
                            end
                        end else if (fifo_empty) begin
                            r_state      <= RD_IDLE;
                            r_burst_done <= 1'b1;
                        end
                    end
                    default: r_state <= RD_IDLE;
                endcase
            end
        end
    end
endmodule
